aes_blk_to_stream: RTL and testbench

- Output-side serializer for the AES accelerator: takes one 128-bit cipher block per handshake and emits it as a 32-bit valid/ack word stream, least-significant word first.
- Carries a per-block last flag onto the final beat.
- Sits between the encrypt core's 128-bit result register slice and the 32-bit AXI-Stream master port.
- Mirror of the input-side word-to-block packer.

---
 rtl/aes_blk_to_stream_if.sv | 29 ++
 rtl/aes_blk_to_stream.sv | 100 ++++++++++
 tb/tb_aes_blk_to_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_blk_to_stream_if.sv
// Bus bundle for the AES block-to-stream serializer.
// The slave modport is the serializer's own view: it receives 128-bit blocks
// and emits 32-bit words. The master modport is the surrounding environment
// (block producer plus stream consumer) driving the opposite directions.
interface aes_blk_to_stream_if #(
    parameter int BLK_WIDTH = 128,
    parameter int DataWidth = 32
);
    logic [BLK_WIDTH-1:0]   blk_data_in;
    logic                   blk_last_in;
    logic                   blk_vld_in;
    logic                   blk_ack_in;
    logic [DataWidth-1:0]   data_out;
    logic [DataWidth/8-1:0] keep_out;
    logic                   last_out;
    logic                   vld_out;
    logic                   ack_out;
    logic                   stall_out;

    modport slave (
        input  blk_data_in, blk_last_in, blk_vld_in, ack_out,
        output blk_ack_in, data_out, keep_out, last_out, vld_out, stall_out
    );

    modport master (
        output blk_data_in, blk_last_in, blk_vld_in, ack_out,
        input  blk_ack_in, data_out, keep_out, last_out, vld_out, stall_out
    );
endinterface

// File: rtl/aes_blk_to_stream.sv
// Output-side serializer for the AES accelerator.
// Accepts one cipher block per handshake and replays it as a valid/ack word
// stream, least-significant word first, tagging the final word with the
// block's last flag. A new block can be taken on the final beat of the
// current one, so back-to-back blocks stream with no idle cycle.
// blk_ack_in depends combinationally on ack_out; downstream must not make
// ack_out depend on blk_ack_in.
module aes_blk_to_stream #(
    parameter int BLK_WIDTH = 128,
    parameter int DataWidth = 32
) (
    input logic                ap_clk,
    input logic                ap_rst,
    aes_blk_to_stream_if.slave bus
);
    localparam int NBEATS = BLK_WIDTH / DataWidth;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                           state;
    state_t                           state_nxt;
    logic [CNT_W-1:0]                 cnt;
    logic [CNT_W-1:0]                 cnt_nxt;
    logic [NBEATS-1:0][DataWidth-1:0] held;
    logic                             held_last;
    logic                             load;
    logic                             blk_ack;
    logic                             beat;
    logic                             final_beat;

    assign beat       = (state == SEND) & bus.ack_out;
    assign final_beat = beat & (cnt == LAST_CNT);

    // State and beat counter; reset drops any partially sent block.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Block hold register; loading is harmless during reset because the
    // state machine ignores its contents while EMPTY.
    always_ff @(posedge ap_clk) begin
        if (load) begin
            held      <= bus.blk_data_in;
            held_last <= bus.blk_last_in;
        end
    end

    // Next-state, counter advance and block acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        blk_ack   = 1'b0;
        case (state)
            EMPTY: begin
                blk_ack = 1'b1;
                if (bus.blk_vld_in) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (final_beat) begin
                    blk_ack = 1'b1;
                    cnt_nxt = '0;
                    if (bus.blk_vld_in) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end else if (beat) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.blk_ack_in = blk_ack;
    assign bus.vld_out    = (state == SEND);
    assign bus.data_out   = held[cnt];
    assign bus.last_out   = (state == SEND) & held_last & (cnt == LAST_CNT);
    assign bus.keep_out   = '1;
    assign bus.stall_out  = (state == SEND) & ~bus.ack_out;
endmodule

// File: tb/tb_aes_blk_to_stream.sv
// Self-checking bench for aes_blk_to_stream.
// A queue-based reference model holds the words still owed downstream: an
// accepted block appends its words (LS word first, last flag on the final
// one), each completed beat removes the head. Outputs are sampled 1 ns after
// the falling edge where inputs change, well away from the rising edge.
module tb_aes_blk_to_stream;
    localparam int BW  = 128;
    localparam int BW2 = 64;
    localparam int DW  = 32;
    localparam int NB  = BW / DW;
    localparam int NB2 = BW2 / DW;

    typedef logic [DW+DW/8+3:0] vec_t;

    logic ap_clk = 1'b0;
    logic ap_rst;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW:0] exp_q[$];
    logic [DW:0] exp_q64[$];
    logic [DW:0] beat_log[$];
    logic [DW:0] beat_log64[$];

    vec_t        exp_v;
    vec_t        obs_v;
    logic        obs_acc;
    logic        obs_beat;
    logic        obs_stall;
    logic [DW:0] obs_word;

    aes_blk_to_stream_if #(.BLK_WIDTH(BW),  .DataWidth(DW)) bus ();
    aes_blk_to_stream_if #(.BLK_WIDTH(BW2), .DataWidth(DW)) bus64 ();

    aes_blk_to_stream #(.BLK_WIDTH(BW), .DataWidth(DW)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    aes_blk_to_stream #(.BLK_WIDTH(BW2), .DataWidth(DW)) dut64 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus64)
    );

    // Free-running 100 MHz clock.
    always #5 ap_clk = ~ap_clk;

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int k = 0; k < NB; k++) b[k*DW +: DW] = $urandom;
        return b;
    endfunction

    // One clock cycle on the 128-bit instance: drive, sample, advance model.
    task automatic cycle(input logic rst, input logic bvld, input logic [BW-1:0] bdata,
                         input logic blast, input logic ack);
        logic exp_vld;
        logic exp_ack;
        @(negedge ap_clk);
        ap_rst          = rst;
        bus.blk_vld_in  = bvld;
        bus.blk_data_in = bdata;
        bus.blk_last_in = blast;
        bus.ack_out     = ack;
        #1;
        exp_vld = (exp_q.size() != 0);
        exp_ack = (exp_q.size() == 0) || (exp_q.size() == 1 && ack);
        exp_v = {exp_vld, exp_ack, exp_vld & ~ack, {(DW/8){1'b1}},
                 exp_vld ? exp_q[0] : {(DW+1){1'b0}}};
        obs_v = {bus.vld_out, bus.blk_ack_in, bus.stall_out, bus.keep_out, bus.last_out,
                 bus.vld_out ? bus.data_out : {DW{1'b0}}};
        obs_acc   = bvld & bus.blk_ack_in;
        obs_beat  = bus.vld_out & ack;
        obs_stall = bus.stall_out;
        obs_word  = {bus.last_out, bus.data_out};
        if (obs_beat === 1'b1) beat_log.push_back(obs_word);
        @(posedge ap_clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_vld && ack) void'(exp_q.pop_front());
            if (bvld && exp_ack)
                for (int k = 0; k < NB; k++)
                    exp_q.push_back({blast && (k == NB - 1), bdata[k*DW +: DW]});
        end
    endtask

    // One clock cycle on the 64-bit instance.
    task automatic cycle64(input logic bvld, input logic [BW2-1:0] bdata,
                           input logic blast, input logic ack);
        logic exp_vld;
        logic exp_ack;
        @(negedge ap_clk);
        ap_rst            = 1'b0;
        bus64.blk_vld_in  = bvld;
        bus64.blk_data_in = bdata;
        bus64.blk_last_in = blast;
        bus64.ack_out     = ack;
        #1;
        exp_vld = (exp_q64.size() != 0);
        exp_ack = (exp_q64.size() == 0) || (exp_q64.size() == 1 && ack);
        exp_v = {exp_vld, exp_ack, exp_vld & ~ack, 4'hF,
                 exp_vld ? exp_q64[0] : {(DW+1){1'b0}}};
        obs_v = {bus64.vld_out, bus64.blk_ack_in, bus64.stall_out, bus64.keep_out,
                 bus64.last_out, bus64.vld_out ? bus64.data_out : {DW{1'b0}}};
        if ((bus64.vld_out & ack) === 1'b1) beat_log64.push_back({bus64.last_out, bus64.data_out});
        @(posedge ap_clk);
        if (exp_vld && ack) void'(exp_q64.pop_front());
        if (bvld && exp_ack)
            for (int k = 0; k < NB2; k++)
                exp_q64.push_back({blast && (k == NB2 - 1), bdata[k*DW +: DW]});
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obs_v, exp_v);
        end
        // Reset together with an offered block: the block must not be taken.
        cycle(1'b1, 1'b1, rand_blk(), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (obs_v !== exp_v || bus.vld_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_wins: got %h expected %h", obs_v, exp_v);
        end
    endtask

    task automatic test_single();
        logic [BW-1:0] blk = 128'h33333333_22222222_11111111_00000000;
        beat_log.delete();
        cycle(1'b0, 1'b1, blk, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL single cycle %0d: got %h expected %h", c, obs_v, exp_v);
            end
            cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        end
        vectors++;
        if (beat_log.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL single_count: got %0d beats expected 4", beat_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (beat_log[k] !== {k == 3, 32'h11111111 * k}) begin
                    miscompares++;
                    $display("[TB] FAIL single_beat%0d: got %h expected %h",
                             k, beat_log[k], {k == 3, 32'h11111111 * k});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] blks[3];
        logic [2:0]    lasts = 3'b100;
        logic [11:0]   last_bits;
        int idx = 0;
        int first = -1;
        int lastc = -1;
        int n = 0;
        for (int b = 0; b < 3; b++) blks[b] = rand_blk();
        beat_log.delete();
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, idx < 3, blks[idx > 2 ? 2 : idx], lasts[idx > 2 ? 2 : idx], 1'b1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL b2b cycle %0d: got %h expected %h", c, obs_v, exp_v);
            end
            if (obs_acc === 1'b1) idx++;
            if (obs_beat === 1'b1) begin
                n++;
                if (first < 0) first = c;
                lastc = c;
            end
        end
        vectors++;
        if (n != 12 || lastc - first + 1 != 12) begin
            miscompares++;
            $display("[TB] FAIL b2b_gapless: got %0d beats over %0d cycles expected 12 over 12",
                     n, lastc - first + 1);
        end
        last_bits = '0;
        for (int k = 0; k < 12 && k < beat_log.size(); k++) last_bits[k] = beat_log[k][DW];
        vectors++;
        if (last_bits !== 12'h800) begin
            miscompares++;
            $display("[TB] FAIL b2b_last_flags: got %h expected 800", last_bits);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]    pat = 4'b1001;
        logic [BW-1:0] pend;
        logic          pend_last;
        logic          pend_vld = 1'b0;
        logic          ack;
        logic          prev_stall = 1'b0;
        logic [DW:0]   prev_word = '0;
        for (int c = 0; c < 240; c++) begin
            if (!pend_vld && (c < 12 ? c == 0 : $urandom_range(0, 1) == 1)) begin
                pend      = rand_blk();
                pend_last = 1'($urandom_range(0, 1));
                pend_vld  = 1'b1;
            end
            ack = (c < 12) ? pat[c % 4] : 1'($urandom_range(0, 1));
            if (c >= 230) ack = 1'b1;
            cycle(1'b0, pend_vld && c < 225, pend, pend_last, ack);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL backpressure cycle %0d: got %h expected %h", c, obs_v, exp_v);
            end
            if (prev_stall) begin
                vectors++;
                if (obs_word !== prev_word) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h",
                             c, obs_word, prev_word);
                end
            end
            if (obs_acc === 1'b1) pend_vld = 1'b0;
            prev_stall = (obs_stall === 1'b1);
            prev_word  = obs_word;
        end
    endtask

    task automatic test_input_stall();
        logic [BW-1:0] a = rand_blk();
        logic [BW-1:0] b = rand_blk();
        int acc_a = -1;
        int acc_b = -1;
        beat_log.delete();
        for (int c = 0; c < 12; c++) begin
            if (acc_a < 0)      cycle(1'b0, 1'b1, a, 1'b0, 1'b1);
            else if (acc_b < 0) cycle(1'b0, 1'b1, b, 1'b1, 1'b1);
            else                cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL input_stall cycle %0d: got %h expected %h", c, obs_v, exp_v);
            end
            if (obs_acc === 1'b1) begin
                if (acc_a < 0) acc_a = c;
                else if (acc_b < 0) acc_b = c;
            end
        end
        vectors++;
        if (acc_a < 0 || acc_b - acc_a != NB) begin
            miscompares++;
            $display("[TB] FAIL input_stall_accept: got gap %0d expected %0d", acc_b - acc_a, NB);
        end
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (beat_log.size() != 2 * NB || beat_log[NB + k] !== {k == NB - 1, b[k*DW +: DW]}) begin
                miscompares++;
                $display("[TB] FAIL input_stall_word%0d: got %0d beats, word %h expected %h", k,
                         beat_log.size(), beat_log.size() > NB + k ? beat_log[NB + k] : '0,
                         {k == NB - 1, b[k*DW +: DW]});
            end
        end
    endtask

    task automatic test_reset_mid_block();
        logic [BW-1:0] aa = {NB{32'hAAAAAAAA}};
        cycle(1'b0, 1'b1, rand_blk(), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (obs_v !== exp_v || bus.vld_out !== 1'b0 || bus.blk_ack_in !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got %h expected %h", obs_v, exp_v);
        end
        beat_log.delete();
        cycle(1'b0, 1'b1, aa, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL after_reset cycle %0d: got %h expected %h", c, obs_v, exp_v);
            end
        end
        vectors++;
        if (beat_log.size() != NB || beat_log[0] !== {1'b0, 32'hAAAAAAAA}) begin
            miscompares++;
            $display("[TB] FAIL after_reset_words: got %0d beats expected %0d", beat_log.size(), NB);
        end
    endtask

    task automatic test_sweep64();
        logic [BW2-1:0] x = {$urandom, $urandom};
        logic [BW2-1:0] y = {$urandom, $urandom};
        logic [3:0]     last_bits = '0;
        beat_log64.delete();
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      cycle64(1'b1, x, 1'b1, 1'b1);
            else if (c <= 2) cycle64(1'b1, y, 1'b0, 1'b1);
            else             cycle64(1'b0, '0, 1'b0, 1'b1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL sweep64 cycle %0d: got %h expected %h", c, obs_v, exp_v);
            end
        end
        for (int k = 0; k < 4 && k < beat_log64.size(); k++) last_bits[k] = beat_log64[k][DW];
        vectors++;
        if (beat_log64.size() != 4 || last_bits !== 4'b0010 || beat_log64[0][DW-1:0] !== x[31:0]) begin
            miscompares++;
            $display("[TB] FAIL sweep64_beats: got %0d beats lasts %b expected 4 beats lasts 0010",
                     beat_log64.size(), last_bits);
        end
    endtask

    initial begin
        ap_rst            = 1'b1;
        bus.blk_vld_in    = 1'b0;
        bus.blk_data_in   = '0;
        bus.blk_last_in   = 1'b0;
        bus.ack_out       = 1'b0;
        bus64.blk_vld_in  = 1'b0;
        bus64.blk_data_in = '0;
        bus64.blk_last_in = 1'b0;
        bus64.ack_out     = 1'b0;
        $display("[TB] starting aes_blk_to_stream checks");
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_input_stall();
        test_reset_mid_block();
        test_sweep64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
